cb_branch: RTL and testbench

// - Clocked branch stage: the fork-side counterpart of the self-timed join element.
// - Accepts one token per four-phase Send/Ack handshake from the self-timed pipeline.
// - Routes each token to output channel 0 or 1 using its destination bit.
// - Sits between an asynchronous join/latch stage and clocked or self-timed consumers.
// - Synchronises every incoming handshake signal to CLK.

---
 rtl/ddp_hs_pkg.sv | 22 ++
 rtl/cb_branch_hs_sync.sv | 24 ++
 rtl/cb_branch.sv | 155 +++++++++++++++
 tb/tb_cb_branch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddp_hs_pkg.sv
// Shared types and defaults for the clocked branch stage and its synchronisers.
package ddp_hs_pkg;

    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned DEST_BIT        = DATA_W_DEF - 1;

    // Input-side handshake FSM
    typedef enum logic [1:0] {
        I_ARM  = 2'd0,
        I_IDLE = 2'd1,
        I_ACK  = 2'd2
    } in_state_t;

    // Output-side handshake FSM
    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_REQ  = 2'd1,
        O_REL  = 2'd2
    } out_state_t;

endpackage

// File: rtl/cb_branch_hs_sync.sv
// Multi-flop synchroniser for one asynchronous handshake wire, cleared by master reset.
module hs_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the asynchronous level through the flop chain
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/cb_branch.sv
// Clocked branch stage: takes tokens from a four-phase self-timed source and
// routes each one to channel 0 or 1 by its top bit, with one buffer slot plus
// the output register of storage.
module cb_branch
    import ddp_hs_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              CLK,
    input  logic              MR,
    input  logic              Send_in,
    input  logic [DATA_W-1:0] Data_in,
    output logic              Ack_out,
    input  logic              Ga,
    output logic              Send_out0,
    input  logic              Ack_in0,
    output logic              Send_out1,
    input  logic              Ack_in1,
    output logic [DATA_W-1:0] Data_out,
    output logic              CP
);

    localparam int unsigned DST   = DATA_W - 1;
    localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 1);

    logic send_s, ga_s, ack0_s, ack1_s;

    hs_sync #(.STAGES(SYNC_STAGES)) u_sync_send (.clk(CLK), .clr(MR), .d(Send_in), .q(send_s));
    hs_sync #(.STAGES(SYNC_STAGES)) u_sync_ga   (.clk(CLK), .clr(MR), .d(Ga),      .q(ga_s));
    hs_sync #(.STAGES(SYNC_STAGES)) u_sync_ack0 (.clk(CLK), .clr(MR), .d(Ack_in0), .q(ack0_s));
    hs_sync #(.STAGES(SYNC_STAGES)) u_sync_ack1 (.clk(CLK), .clr(MR), .d(Ack_in1), .q(ack1_s));

    in_state_t         in_state, in_next;
    out_state_t        out_state, out_next;
    logic [ARM_W-1:0]  arm_cnt, arm_cnt_next;
    logic [DATA_W-1:0] buf_q;
    logic              buf_full;
    logic              dest_q, dest_next;
    logic              ack_next, cp_next, s0_next, s1_next;
    logic              capture, drain, ack_sel;

    assign ack_sel = dest_q ? ack1_s : ack0_s;

    // State, control and output registers
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            in_state  <= I_ARM;
            out_state <= O_IDLE;
            arm_cnt   <= '0;
            dest_q    <= 1'b0;
            Ack_out   <= 1'b0;
            CP        <= 1'b0;
            Send_out0 <= 1'b0;
            Send_out1 <= 1'b0;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
            arm_cnt   <= arm_cnt_next;
            dest_q    <= dest_next;
            Ack_out   <= ack_next;
            CP        <= cp_next;
            Send_out0 <= s0_next;
            Send_out1 <= s1_next;
        end
    end

    // Buffer slot and shared output data register
    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            buf_q    <= '0;
            buf_full <= 1'b0;
            Data_out <= '0;
        end else begin
            if (capture) begin
                buf_q <= Data_in;
            end
            if (capture) begin
                buf_full <= 1'b1;
            end else if (drain) begin
                buf_full <= 1'b0;
            end
            if (drain) begin
                Data_out <= buf_q;
            end
        end
    end

    // Next-state and output decode for both handshake FSMs
    always_comb begin
        in_next      = in_state;
        out_next     = out_state;
        arm_cnt_next = arm_cnt;
        dest_next    = dest_q;
        ack_next     = Ack_out;
        cp_next      = 1'b0;
        s0_next      = Send_out0;
        s1_next      = Send_out1;
        capture      = 1'b0;
        drain        = 1'b0;

        unique case (out_state)
            O_IDLE: begin
                if (buf_full) begin
                    drain     = 1'b1;
                    dest_next = buf_q[DST];
                    s0_next   = !buf_q[DST];
                    s1_next   = buf_q[DST];
                    out_next  = O_REQ;
                end
            end
            O_REQ: begin
                if (ack_sel) begin
                    s0_next  = 1'b0;
                    s1_next  = 1'b0;
                    out_next = O_REL;
                end
            end
            O_REL: begin
                if (!ack_sel) begin
                    out_next = O_IDLE;
                end
            end
            default: out_next = O_IDLE;
        endcase

        unique case (in_state)
            // Synchroniser output is forced low by reset, so only trust it
            // once the chain has refilled with the live Send_in level.
            I_ARM: begin
                if (arm_cnt != ARM_W'(SYNC_STAGES)) begin
                    arm_cnt_next = arm_cnt + ARM_W'(1);
                end else if (!send_s) begin
                    in_next = I_IDLE;
                end
            end
            I_IDLE: begin
                if (send_s && ga_s && (!buf_full || drain)) begin
                    capture  = 1'b1;
                    ack_next = 1'b1;
                    cp_next  = 1'b1;
                    in_next  = I_ACK;
                end
            end
            I_ACK: begin
                if (!send_s) begin
                    ack_next = 1'b0;
                    in_next  = I_IDLE;
                end
            end
            default: in_next = I_ARM;
        endcase
    end

endmodule

// File: tb/tb_cb_branch.sv
// Self-checking bench for cb_branch: directed protocol steps followed by a
// randomized token stream checked against an in-order token queue.
module tb_cb_branch;

    localparam int unsigned DW   = 16;
    localparam int unsigned SYNC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          send_in;
    logic [DW-1:0] data_in;
    logic          ack_out;
    logic          ga;
    logic          send_out0;
    logic          ack_in0;
    logic          send_out1;
    logic          ack_in1;
    logic [DW-1:0] data_out;
    logic          cp;

    int vectors     = 0;
    int miscompares = 0;
    logic run_mon   = 1'b0;
    logic [DW-1:0] exp_q[$];

    cb_branch #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
        .CLK      (clk),
        .MR       (rst),
        .Send_in  (send_in),
        .Data_in  (data_in),
        .Ack_out  (ack_out),
        .Ga       (ga),
        .Send_out0(send_out0),
        .Ack_in0  (ack_in0),
        .Send_out1(send_out1),
        .Ack_in1  (ack_in1),
        .Data_out (data_out),
        .CP       (cp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return ack_out;
            1:       return send_out0;
            2:       return send_out1;
            default: return cp;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int w, input logic val, input int budget);
        int n = 0;
        while (sig(w) !== val && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(sig(w)), 32'(val));
    endtask

    // Full upstream handshake for one token
    task automatic produce(input logic [DW-1:0] d);
        data_in = d;
        send_in = 1'b1;
        wait_for("prod_ack_hi", 0, 1'b1, 400);
        send_in = 1'b0;
        wait_for("prod_ack_lo", 0, 1'b0, 40);
    endtask

    // Full downstream handshake for one token on whichever channel requests
    task automatic consume(input logic [DW-1:0] exp, input int dly);
        int   n = 0;
        logic ch;
        while (!(send_out0 || send_out1) && n < 400) begin
            tick();
            n++;
        end
        check("cons_req", 32'(send_out0 | send_out1), 32'd1);
        ch = send_out1;
        check("cons_chan", 32'(ch), 32'(exp[DW-1]));
        check("cons_data", 32'(data_out), 32'(exp));
        repeat (dly) tick();
        check("cons_data_stable", 32'(data_out), 32'(exp));
        if (ch) ack_in1 = 1'b1;
        else    ack_in0 = 1'b1;
        wait_for(ch ? "cons_rel1" : "cons_rel0", ch ? 2 : 1, 1'b0, 40);
        ack_in0 = 1'b0;
        ack_in1 = 1'b0;
        repeat (SYNC + 1) tick();
    endtask

    // Both request lines must never be high together
    always @(negedge clk) begin
        if (run_mon && !rst) begin
            check("mutex_send", 32'(send_out0 & send_out1), 32'd0);
        end
    end

    initial begin
        rst     = 1'b1;
        send_in = 1'b0;
        data_in = '0;
        ga      = 1'b1;
        ack_in0 = 1'b0;
        ack_in1 = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ack", 32'(ack_out), 32'd0);
        check("rst_s0", 32'(send_out0), 32'd0);
        check("rst_s1", 32'(send_out1), 32'd0);
        check("rst_cp", 32'(cp), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        rst = 1'b0;
        run_mon = 1'b1;
        repeat (6) tick();

        // Channel 0 token with latency check
        data_in = 16'h0005;
        send_in = 1'b1;
        tick(); tick();
        check("lat_ack_early", 32'(ack_out), 32'd0);
        tick();
        check("lat_ack", 32'(ack_out), 32'd1);
        check("lat_cp", 32'(cp), 32'd1);
        tick();
        check("lat_cp_one", 32'(cp), 32'd0);
        check("lat_s0", 32'(send_out0), 32'd1);
        check("lat_s1", 32'(send_out1), 32'd0);
        check("lat_data", 32'(data_out), 32'h0005);
        send_in = 1'b0;
        wait_for("t2_ack_lo", 0, 1'b0, 40);
        consume(16'h0005, 2);

        // Channel 1 token; channel 0 acknowledge is ignored
        data_in = 16'h8003;
        send_in = 1'b1;
        repeat (SYNC + 2) tick();
        check("t3_s1", 32'(send_out1), 32'd1);
        check("t3_s0", 32'(send_out0), 32'd0);
        check("t3_data", 32'(data_out), 32'h8003);
        ack_in0 = 1'b1;
        repeat (6) tick();
        check("t3_ign_s1", 32'(send_out1), 32'd1);
        check("t3_ign_s0", 32'(send_out0), 32'd0);
        ack_in0 = 1'b0;
        repeat (4) tick();
        send_in = 1'b0;
        wait_for("t3_ack_lo", 0, 1'b0, 40);
        consume(16'h8003, 1);

        // Capacity of two, third token stalls until the first drains
        produce(16'h0001);
        produce(16'h0002);
        data_in = 16'h0003;
        send_in = 1'b1;
        repeat (10) tick();
        check("t4_stall_ack", 32'(ack_out), 32'd0);
        consume(16'h0001, 0);
        wait_for("t4_ack3", 0, 1'b1, 40);
        send_in = 1'b0;
        wait_for("t4_ack3_lo", 0, 1'b0, 40);
        consume(16'h0002, 1);
        consume(16'h0003, 0);

        // Gate low blocks captures
        ga = 1'b0;
        repeat (SYNC + 1) tick();
        data_in = 16'h8010;
        send_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_gate_ack", 32'(ack_out), 32'd0);
            check("t5_gate_cp", 32'(cp), 32'd0);
        end
        ga = 1'b1;
        tick(); tick();
        check("t5_ack_early", 32'(ack_out), 32'd0);
        tick();
        check("t5_ack", 32'(ack_out), 32'd1);
        check("t5_cp", 32'(cp), 32'd1);
        send_in = 1'b0;
        wait_for("t5_ack_lo", 0, 1'b0, 40);
        consume(16'h8010, 0);

        // Master reset mid-cycle with Send_in held high
        produce(16'h0007);
        wait_for("t6_s0", 1, 1'b1, 40);
        data_in = 16'h00AA;
        send_in = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mr_ack", 32'(ack_out), 32'd0);
        check("mr_s0", 32'(send_out0), 32'd0);
        check("mr_s1", 32'(send_out1), 32'd0);
        check("mr_cp", 32'(cp), 32'd0);
        check("mr_data", 32'(data_out), 32'd0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t6_held_ack", 32'(ack_out), 32'd0);
            check("t6_held_cp", 32'(cp), 32'd0);
        end
        check("t6_s0", 32'(send_out0), 32'd0);
        send_in = 1'b0;
        repeat (5) tick();
        produce(16'h0009);
        consume(16'h0009, 0);

        // Randomized stream against an in-order token queue
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [DW-1:0] d;
                    repeat ($urandom_range(0, 6)) tick();
                    d = DW'($urandom);
                    data_in = d;
                    send_in = 1'b1;
                    wait_for("rnd_ack_hi", 0, 1'b1, 400);
                    exp_q.push_back(d);
                    send_in = 1'b0;
                    wait_for("rnd_ack_lo", 0, 1'b0, 40);
                end
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [DW-1:0] e;
                    int n = 0;
                    while (exp_q.size() == 0 && n < 400) begin
                        tick();
                        n++;
                    end
                    check("rnd_queue", 32'(exp_q.size() != 0), 32'd1);
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                    consume(e, $urandom_range(0, 5));
                end
            end
        join
        repeat (5) tick();
        check("rnd_drained_s0", 32'(send_out0), 32'd0);
        check("rnd_drained_s1", 32'(send_out1), 32'd0);
        run_mon = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
